// File: rtl/pkt_serializer_528b.sv
// Drains 528-bit packet entries from a first-word-fall-through FIFO and replays each
// entry's 512-bit payload as OUT_W-bit beats on a valid/ready stream with sop/eop/mod sideband.
module pkt_serializer_528b #(
  parameter int OUT_W = 128,
  parameter int MOD_W = $clog2(OUT_W / 8)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [527:0]     i_fifo_dout,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sop,
  output logic             o_eop,
  output logic [MOD_W-1:0] o_mod,
  output logic [31:0]      o_pkt_cnt
);

  localparam int BYTES = OUT_W / 8;
  localparam int BEATS = 512 / OUT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                       state;
  logic [527:0]                 r_word;
  logic [IDX_W-1:0]             beat_idx;
  logic [6:0]                   n_raw;
  logic [6:0]                   n_eff;
  logic [7:0]                   nb;
  logic                         last;
  logic                         accept;
  logic [BEATS-1:0][OUT_W-1:0]  beats;
  logic                         unused_rsvd;

  // A byte count of zero or anything above 64 means the whole 64-byte payload.
  assign n_raw  = r_word[518:512];
  assign n_eff  = (n_raw == 7'd0 || n_raw > 7'd64) ? 7'd64 : n_raw;
  assign nb     = ({1'b0, n_eff} + 8'(BYTES - 1)) >> MOD_W;
  assign last   = (8'(beat_idx) == nb - 8'd1);
  assign accept = o_valid & i_ready;

  assign beats  = r_word[511:0];
  assign o_data = beats[beat_idx];
  assign o_sop  = o_valid & r_word[527] & (beat_idx == '0);
  assign o_eop  = o_valid & r_word[526] & last;
  assign o_mod  = o_eop ? n_eff[MOD_W-1:0] : '0;

  assign unused_rsvd = ^r_word[525:519];

  // Pop in IDLE whenever data is waiting, or on the accepted last beat so entries chain without a bubble.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    o_fifo_rd_en = 1'b0;
    if (!srst && !i_fifo_empty) begin
      case (state)
        IDLE:    o_fifo_rd_en = 1'b1;
        SEND:    o_fifo_rd_en = accept & last;
        default: o_fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      // NOTE: the held entry is a plain register, not a RAM, so clearing it on reset is cheap and keeps o_data defined.
      state     <= IDLE;
      r_word    <= '0;
      beat_idx  <= '0;
      o_valid   <= 1'b0;
      o_pkt_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (o_fifo_rd_en) begin
            r_word   <= i_fifo_dout;
            beat_idx <= '0;
            o_valid  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (o_eop) o_pkt_cnt <= o_pkt_cnt + 32'd1;
            if (!last) begin
              beat_idx <= beat_idx + IDX_W'(1);
            end else if (o_fifo_rd_en) begin
              r_word   <= i_fifo_dout;
              beat_idx <= '0;
            end else begin
              o_valid <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_serializer_528b.sv
// Bench for pkt_serializer_528b: FIFO model plus per-entry beat scoreboard built from the
// byte-count rules, directed vector table, multi-cycle corner sequences and random backpressure.
module tb_pkt_serializer_528b;

  localparam int OUT_W = 128;
  localparam int BYTES = OUT_W / 8;
  localparam int MOD_W = 4;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sop;
    logic             eop;
    logic [MOD_W-1:0] mod;
    logic             last;
  } beat_t;

  typedef struct {
    bit sop;
    bit eop;
    int n;
    int exp_beats;
    int exp_mod;
    bit exp_last_eop;
    int exp_pkts;
  } vec_t;

  logic             clk;
  logic             srst;
  logic [527:0]     i_fifo_dout;
  logic             i_fifo_empty;
  logic             o_fifo_rd_en;
  logic [OUT_W-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_sop;
  logic             o_eop;
  logic [MOD_W-1:0] o_mod;
  logic [31:0]      o_pkt_cnt;

  pkt_serializer_528b #(.OUT_W(OUT_W), .MOD_W(MOD_W)) dut (
    .clk          (clk),
    .srst         (srst),
    .i_fifo_dout  (i_fifo_dout),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sop        (o_sop),
    .o_eop        (o_eop),
    .o_mod        (o_mod),
    .o_pkt_cnt    (o_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [527:0] fifo_q[$];
  beat_t        exp_q[$];
  bit           exp_valid = 1'b0;
  int           exp_pkts = 0;
  bit           rand_ready = 1'b0;
  int           cyc = 0;
  int           acc_beats, rd_pulses, last_mod, valid_cycles, first_valid_cyc, last_acc_cyc;
  bit           last_eop;

  task automatic check(input string name, input logic [527:0] act, input logic [527:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_dout  = i_fifo_empty ? '0 : fifo_q[0];
  endtask

  // Queue an entry upstream and derive its expected beats from the byte-count rules.
  task automatic push_entry(input bit sop, input bit eop, input int n, input logic [511:0] data);
    int    n_eff;
    int    nb;
    beat_t b;
    fifo_q.push_back({sop, eop, 7'($urandom), 7'(n), data});
    n_eff = (n == 0 || n > 64) ? 64 : n;
    nb    = (n_eff + BYTES - 1) / BYTES;
    for (int k = 0; k < nb; k++) begin
      b.data = data[k*OUT_W +: OUT_W];
      b.sop  = sop && (k == 0);
      b.last = (k == nb - 1);
      b.eop  = eop && b.last;
      b.mod  = b.eop ? MOD_W'(n_eff % BYTES) : '0;
      exp_q.push_back(b);
    end
    drive_fifo();
  endtask

  // One clock: compare at the falling edge, advance model and inputs just after the rising edge.
  task automatic step();
    bit    exp_rd;
    bit    acc;
    bit    macc;
    bit    pop;
    bit    was_last;
    beat_t b;
    @(negedge clk);
    exp_rd = !i_fifo_empty && (!exp_valid || (i_ready && exp_q.size() > 0 && exp_q[0].last));
    check("rd_en", o_fifo_rd_en, exp_rd);
    check("valid", o_valid, exp_valid);
    check("pkt_cnt", o_pkt_cnt, exp_pkts);
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", o_valid, 1'b0);
      end else begin
        check("data", o_data, exp_q[0].data);
        check("sop", o_sop, exp_q[0].sop);
        check("eop", o_eop, exp_q[0].eop);
        check("mod", o_mod, exp_q[0].mod);
      end
      if (valid_cycles == 0) first_valid_cyc = cyc;
      valid_cycles++;
    end
    acc  = o_valid && i_ready;
    macc = exp_valid && i_ready;
    pop  = o_fifo_rd_en;
    if (acc) begin
      acc_beats++;
      last_mod     = int'(o_mod);
      last_eop     = o_eop;
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    was_last = 1'b0;
    if (macc && exp_q.size() > 0) begin
      b        = exp_q.pop_front();
      was_last = b.last;
      if (b.eop) exp_pkts++;
    end
    if (exp_rd)        exp_valid = 1'b1;
    else if (was_last) exp_valid = 1'b0;
    if (pop && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      rd_pulses++;
    end
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    drive_fifo();
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || exp_valid || fifo_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check("drain_in_budget", (k < budget), 1'b1);
  endtask

  // Reset discards any entry already popped; entries still upstream survive.
  task automatic reset_pulse(input int cycles);
    beat_t b;
    srst = 1'b1;
    if (exp_valid) begin
      while (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        if (b.last) break;
      end
    end
    exp_valid = 1'b0;
    exp_pkts  = 0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_valid", o_valid, 1'b0);
      check("rst_rd_en", o_fifo_rd_en, 1'b0);
      check("rst_pkt_cnt", o_pkt_cnt, 32'd0);
      check("rst_data", o_data, '0);
    end
    @(posedge clk);
    #1;
    srst = 1'b0;
  endtask

  task automatic clear_stats();
    acc_beats    = 0;
    rd_pulses    = 0;
    last_mod     = 99;
    last_eop     = 1'b0;
    valid_cycles = 0;
    first_valid_cyc = 0;
    last_acc_cyc    = 0;
  endtask

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sop: 1, eop: 1, n: 64,  exp_beats: 4, exp_mod: 0, exp_last_eop: 1, exp_pkts: 1};
    vecs[1] = '{sop: 1, eop: 1, n: 20,  exp_beats: 2, exp_mod: 4, exp_last_eop: 1, exp_pkts: 1};
    vecs[2] = '{sop: 1, eop: 1, n: 0,   exp_beats: 4, exp_mod: 0, exp_last_eop: 1, exp_pkts: 1};
    vecs[3] = '{sop: 1, eop: 1, n: 100, exp_beats: 4, exp_mod: 0, exp_last_eop: 1, exp_pkts: 1};
    vecs[4] = '{sop: 1, eop: 1, n: 16,  exp_beats: 1, exp_mod: 0, exp_last_eop: 1, exp_pkts: 1};
    vecs[5] = '{sop: 1, eop: 1, n: 17,  exp_beats: 2, exp_mod: 1, exp_last_eop: 1, exp_pkts: 1};
    vecs[6] = '{sop: 0, eop: 1, n: 1,   exp_beats: 1, exp_mod: 1, exp_last_eop: 1, exp_pkts: 1};
    vecs[7] = '{sop: 1, eop: 0, n: 33,  exp_beats: 3, exp_mod: 0, exp_last_eop: 0, exp_pkts: 0};

    srst    = 1'b1;
    i_ready = 1'b1;
    drive_fifo();
    clear_stats();

    // Reset held while the FIFO already has an entry: no pop until release.
    push_entry(1'b1, 1'b1, 64, rand512());
    reset_pulse(3);
    run_until_idle(40);
    check("t1_rd_pulses", rd_pulses, 1);
    check("t1_beats", acc_beats, 4);

    // Single-entry table, each vector starting from reset so o_pkt_cnt is absolute.
    foreach (vecs[i]) begin
      reset_pulse(1);
      clear_stats();
      push_entry(vecs[i].sop, vecs[i].eop, vecs[i].n, rand512());
      run_until_idle(40);
      step();
      step();
      check("tbl_beats", acc_beats, vecs[i].exp_beats);
      check("tbl_mod", last_mod, vecs[i].exp_mod);
      check("tbl_last_eop", last_eop, vecs[i].exp_last_eop);
      check("tbl_rd_pulses", rd_pulses, 1);
      check("tbl_pkt_cnt", o_pkt_cnt, vecs[i].exp_pkts);
    end

    // Two-entry packet queued together: seven beats with no bubble between entries.
    reset_pulse(1);
    clear_stats();
    push_entry(1'b1, 1'b0, 64, rand512());
    push_entry(1'b0, 1'b1, 33, rand512());
    run_until_idle(40);
    check("t4_beats", acc_beats, 7);
    check("t4_span", last_acc_cyc - first_valid_cyc + 1, 7);
    check("t4_rd_pulses", rd_pulses, 2);
    check("t4_mod", last_mod, 1);
    check("t4_pkt_cnt", o_pkt_cnt, 32'd1);

    // FIFO runs dry: back to idle, then a late entry pops and shows its first beat one cycle later.
    reset_pulse(1);
    clear_stats();
    push_entry(1'b1, 1'b1, 40, rand512());
    run_until_idle(40);
    repeat (5) step();
    check("t6_idle_valid", o_valid, 1'b0);
    rd_pulses = 0;
    push_entry(1'b1, 1'b1, 8, rand512());
    step();
    check("t6_pop", rd_pulses, 1);
    check("t6_first_beat", o_valid, 1'b1);
    run_until_idle(40);

    // Reset in the middle of an entry drops the rest of it.
    reset_pulse(1);
    push_entry(1'b1, 1'b1, 64, rand512());
    step();
    step();
    reset_pulse(2);
    clear_stats();
    push_entry(1'b1, 1'b1, 24, rand512());
    run_until_idle(40);
    check("rst_mid_beats", acc_beats, 2);

    // Random traffic with 50% backpressure.
    reset_pulse(1);
    clear_stats();
    rand_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0)
        push_entry(1'($urandom), 1'($urandom), int'($urandom_range(0, 127)), rand512());
      step();
    end
    rand_ready = 1'b0;
    i_ready    = 1'b1;
    run_until_idle(400);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
